ifetch_buffer: RTL and testbench

//  Parametrised instruction-fetch front end between the ibus and decode. Issues sequential

---
 rtl/ifetch_buffer_pkg.sv | 11 +
 rtl/ifetch_buffer_fifo.sv | 35 +++
 rtl/ifetch_buffer.sv | 98 +++++++++
 tb/tb_ifetch_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_buffer_pkg.sv
// ifetch_buffer_pkg: shared entry and state types for the instruction-fetch front end
package ifetch_buffer_pkg;
    localparam int PKG_XLEN = 64;
    localparam int PKG_ILEN = 32;
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} ifb_state_t;
    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_ILEN-1:0] instr;
        logic                fault;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_buffer_fifo.sv
// fetch_fifo: circular instruction queue with flush that overrides push and pop
module fetch_fifo import ifetch_buffer_pkg::*; #(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  T            push_data,
    input  logic        pop,
    output logic [AW:0] count,
    output T            head
);
    T mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];
    // pointer update; the extra pointer bit tells full from empty
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    // storage write for an accepted push
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: sequential fetch FSM with reserved queue credits and redirect flush
module ifetch_buffer import ifetch_buffer_pkg::*; #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_data_ok,
    input  logic [ILEN-1:0] iresp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic            out_fault,
    output logic            busy
);
    localparam int AW = $clog2(DEPTH);
    ifb_state_t      state;
    logic [XLEN-1:0] fetch_pc;
    logic            stall;
    logic [AW:0]     count;
    logic [AW+1:0]   used;
    logic            room;
    logic            push;
    logic            pop;
    fetch_entry_t    push_data;
    fetch_entry_t    head;
    assign used      = {1'b0, count} + (AW+2)'(state == REQ);
    assign room      = used < (AW+2)'(DEPTH);
    assign push      = !redirect && ((state == REQ && iresp_data_ok) ||
                       (state == IDLE && room && !stall && fetch_pc[1:0] != 2'b00));
    assign push_data = state == REQ ? {ireq_addr, iresp_data, 1'b0} : {fetch_pc, {ILEN{1'b0}}, 1'b1};
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign out_pc    = out_valid ? head.pc : '0;
    assign out_instr = out_valid ? head.instr : '0;
    assign out_fault = out_valid && head.fault;
    assign busy      = state != IDLE;

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    // fetch FSM: redirect wins, a slot is reserved before any request issues
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            stall      <= 1'b0;
            ireq_valid <= 1'b0;
            ireq_addr  <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            stall    <= 1'b0;
            if (state == REQ && !iresp_data_ok) begin
                state <= DISCARD;
            end else if (state != IDLE && iresp_data_ok) begin
                state      <= IDLE;
                ireq_valid <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: if (room && !stall) begin
                    if (fetch_pc[1:0] == 2'b00) begin
                        state      <= REQ;
                        ireq_valid <= 1'b1;
                        ireq_addr  <= fetch_pc;
                    end else begin
                        stall <= 1'b1;
                    end
                end
                REQ: if (iresp_data_ok) begin
                    state      <= IDLE;
                    ireq_valid <= 1'b0;
                    fetch_pc   <= fetch_pc + XLEN'(4);
                end
                DISCARD: if (iresp_data_ok) begin
                    state      <= IDLE;
                    ireq_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: scoreboard bench for the fetch buffer with a latency-configurable bus model
module tb_ifetch_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic        busy;

    logic        auto_bus = 1'b1;
    logic        bus_ok = 1'b0;
    logic [31:0] bus_data = '0;
    logic        man_ok = 1'b0;
    logic [31:0] man_data = '0;
    int          bus_lat = 1;
    int          wait_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    logic [96:0] exp_out[$];
    logic [63:0] exp_req[$];
    logic        prev_valid = 1'b0;
    logic        prev_ok = 1'b0;
    logic [63:0] prev_addr = '0;

    assign iresp_data_ok = auto_bus ? bus_ok : man_ok;
    assign iresp_data    = auto_bus ? bus_data : man_data;

    always #5 clk = ~clk;

    ifetch_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_fault     (out_fault),
        .busy          (busy)
    );

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [63:0] base);
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back(base + 64'(4 * i));
            exp_out.push_back({base + 64'(4 * i), instr_of(base + 64'(4 * i)), 1'b0});
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!ireq_valid && n < 40) begin
            cyc(1);
            n++;
        end
        check("req_seen", ireq_valid, 1);
    endtask

    // memory model: answers each request bus_lat cycles after it appears
    initial forever begin
        @(posedge clk);
        #1;
        bus_ok = 1'b0;
        if (auto_bus && ireq_valid && !reset) begin
            if (wait_cnt >= bus_lat) begin
                bus_ok   = 1'b1;
                bus_data = instr_of(ireq_addr);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // request monitor: new addresses against the queue, held requests against the bus rule
    initial forever begin
        @(negedge clk);
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ok) begin
                check("req_hold_valid", ireq_valid, 1);
                check("req_hold_addr", ireq_addr, prev_addr);
            end else if (prev_valid) begin
                check("req_drop_after_ok", ireq_valid, 0);
            end else if (ireq_valid) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req actual=%0h required=none", ireq_addr);
                end else begin
                    check("req_addr", ireq_addr, exp_req.pop_front());
                end
            end
            prev_valid = ireq_valid;
            prev_ok    = iresp_data_ok;
            prev_addr  = ireq_addr;
        end
    end

    // output monitor: every accepted head against the expected entry queue
    initial forever begin
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%0h required=none", out_pc);
            end else begin
                check("out_entry", {out_pc, out_instr, out_fault}, exp_out.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(3);
        check("rst_ireq_valid", ireq_valid, 0);
        check("rst_ireq_addr", ireq_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_fault", out_fault, 0);
        check("rst_busy", busy, 0);
        fill(64'h8000_0000);
        reset = 1'b0;
        cyc(30);
        check("t1_full_valid", out_valid, 1);
        check("t1_idle_when_full", busy, 0);
        check("t1_head_pc", out_pc, 64'h8000_0000);
        check("t1_head_instr", out_instr, 32'h0000_0013);
        fill(64'h8000_0010);
        out_ready = 1'b1;
        cyc(1);
        check("t2_no_req_before_free", ireq_valid, 0);
        cyc(1);
        check("t2_refill_req", ireq_valid, 1);
        cyc(2);
        out_ready = 1'b0;
        cyc(25);
        check("t2_refilled_head", out_pc, 64'h8000_0010);
        bus_lat = 5;
        exp_req.push_back(64'h8000_0020);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        wait_req();
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0100;
        exp_out.delete();
        cyc(1);
        redirect = 1'b0;
        check("t3_flushed", out_valid, 0);
        check("t3_discard_busy", busy, 1);
        fill(64'h8000_0100);
        for (int i = 0; i < 40 && busy; i++) cyc(1);
        check("t3_discard_done", busy, 0);
        check("t3_nothing_enqueued", out_valid, 0);
        bus_lat = 1;
        cyc(30);
        auto_bus = 1'b0;
        exp_req.push_back(64'h8000_0110);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        wait_req();
        man_ok      = 1'b1;
        man_data    = 32'hDEAD_BEEF;
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0300;
        exp_out.delete();
        cyc(1);
        man_ok   = 1'b0;
        redirect = 1'b0;
        auto_bus = 1'b1;
        check("t4_no_discard", busy, 0);
        check("t4_req_dropped", ireq_valid, 0);
        check("t4_resp_not_queued", out_valid, 0);
        fill(64'h8000_0300);
        cyc(30);
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0102;
        exp_out.delete();
        exp_out.push_back({64'h8000_0102, 32'h0, 1'b1});
        cyc(1);
        redirect = 1'b0;
        cyc(5);
        check("t5_fault_valid", out_valid, 1);
        check("t5_fault_flag", out_fault, 1);
        check("t5_fault_pc", out_pc, 64'h8000_0102);
        check("t5_fault_instr", out_instr, 0);
        check("t5_no_bus", ireq_valid, 0);
        out_ready = 1'b1;
        cyc(4);
        check("t5_single_fault", out_valid, 0);
        out_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0200;
        fill(64'h8000_0200);
        cyc(1);
        redirect = 1'b0;
        cyc(30);
        bus_lat = 5;
        exp_req.push_back(64'h8000_0210);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        wait_req();
        cyc(1);
        reset = 1'b1;
        exp_out.delete();
        cyc(1);
        check("t6_reset_req", ireq_valid, 0);
        check("t6_reset_out", out_valid, 0);
        check("t6_reset_busy", busy, 0);
        bus_lat = 1;
        fill(64'h8000_0000);
        reset = 1'b0;
        cyc(30);
        check("t6_restart_pc", out_pc, 64'h8000_0000);
        auto_bus = 1'b0;
        exp_req.push_back(64'h8000_0010);
        out_ready = 1'b1;
        cyc(8);
        out_ready = 1'b0;
        cyc(2);
        check("end_out_drained", exp_out.size(), 0);
        check("end_req_drained", exp_req.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
